// File: rtl/updown_counter_p.sv
// Parametrised up/down counter with parallel load, wrap/saturate modes,
// boundary flags and wrap pulse. Optional sticky event flag: UDC_EVENT_FLAG_EN.
`timescale 1ns/1ps
module updown_counter_p #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = WIDTH'((64'd1 << WIDTH) - 64'd1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             direction,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             saturate,
    output logic [WIDTH-1:0] counter_out,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse
`ifdef UDC_EVENT_FLAG_EN
    ,
    input  logic             event_clr,
    output logic             event_flag
`endif
);

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;

    assign at_max = (counter_out == MAX_VAL);
    assign at_min = (counter_out == '0);

    // Next count: load beats enable; boundaries wrap at MAX_VAL, not 2**WIDTH.
    always_comb begin
        count_next = counter_out;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (enable) begin
            if (direction) begin
                if (!at_max) begin
                    count_next = WIDTH'(counter_out + WIDTH'(1));
                end else if (!saturate) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    count_next = WIDTH'(counter_out - WIDTH'(1));
                end else if (!saturate) begin
                    count_next = MAX_VAL;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_out <= '0;
            wrap_pulse  <= 1'b0;
        end else begin
            counter_out <= count_next;
            wrap_pulse  <= wrap_next;
        end
    end

`ifdef UDC_EVENT_FLAG_EN
    // Any count attempt past a boundary, whether it wraps or is clamped.
    logic boundary_hit;
    assign boundary_hit = !load && enable && (direction ? at_max : at_min);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_flag <= 1'b0;
        end else if (boundary_hit) begin
            event_flag <= 1'b1;
        end else if (event_clr) begin
            event_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_updown_counter_p.sv
// Scoreboard bench for updown_counter_p: two instances (MAX_VAL=255 and 9)
// share stimulus; an integer reference model predicts each edge.
`timescale 1ns/1ps
module tb_updown_counter_p;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, direction, load, saturate;
    logic [7:0] load_value;
    logic [7:0] cnt_a, cnt_b;
    logic       max_a, max_b, min_a, min_b, wrap_a, wrap_b;
`ifdef UDC_EVENT_FLAG_EN
    logic       event_clr;
    logic       flag_a, flag_b;
`endif

    always #5 clk = ~clk;

    updown_counter_p #(.WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .direction(direction),
        .load(load), .load_value(load_value), .saturate(saturate),
        .counter_out(cnt_a), .at_max(max_a), .at_min(min_a), .wrap_pulse(wrap_a)
`ifdef UDC_EVENT_FLAG_EN
        , .event_clr(event_clr), .event_flag(flag_a)
`endif
    );

    updown_counter_p #(.WIDTH(8), .MAX_VAL(8'd9)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .direction(direction),
        .load(load), .load_value(load_value), .saturate(saturate),
        .counter_out(cnt_b), .at_max(max_b), .at_min(min_b), .wrap_pulse(wrap_b)
`ifdef UDC_EVENT_FLAG_EN
        , .event_clr(event_clr), .event_flag(flag_b)
`endif
    );

    typedef struct {
        int c0, c1;
        bit w0, w1, f0, f1;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int   mcnt[2];
    bit   mwrap[2];
    bit   mflag[2];
    int   mmax[2] = '{255, 9};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model one edge for instance idx using unbounded integer arithmetic.
    task automatic model(input int idx, input bit clr);
        int  r;
        bit  crossed;
        int  m;
        m = mmax[idx] + 1;
        crossed = 1'b0;
        mwrap[idx] = 1'b0;
        if (load) begin
            mcnt[idx] = (int'(load_value) < mmax[idx]) ? int'(load_value) : mmax[idx];
        end else if (enable) begin
            r = direction ? mcnt[idx] + 1 : mcnt[idx] - 1;
            crossed = (r > mmax[idx]) || (r < 0);
            if (!crossed)       mcnt[idx] = r;
            else if (!saturate) begin
                mcnt[idx]  = ((r % m) + m) % m;
                mwrap[idx] = 1'b1;
            end
        end
        if (crossed)  mflag[idx] = 1'b1;
        else if (clr) mflag[idx] = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mwrap[i] = 1'b0; mflag[i] = 1'b0;
        end
    endtask

    // Drive one edge's inputs on the falling edge and queue the prediction.
    task automatic step(input bit en, input bit dir, input bit ld, input int lv,
                        input bit sat, input bit clr);
        exp_t e;
        @(negedge clk);
        enable = en; direction = dir; load = ld; load_value = 8'(lv); saturate = sat;
`ifdef UDC_EVENT_FLAG_EN
        event_clr = clr;
`endif
        model(0, clr);
        model(1, clr);
        e.c0 = mcnt[0]; e.c1 = mcnt[1];
        e.w0 = mwrap[0]; e.w1 = mwrap[1];
        e.f0 = mflag[0]; e.f1 = mflag[1];
        sb.push_back(e);
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".cnt_a"}, int'(cnt_a), e.c0);
        check({tag, ".cnt_b"}, int'(cnt_b), e.c1);
        check({tag, ".wrap_a"}, int'(wrap_a), int'(e.w0));
        check({tag, ".wrap_b"}, int'(wrap_b), int'(e.w1));
        check({tag, ".max_a"}, int'(max_a), int'(e.c0 == 255));
        check({tag, ".max_b"}, int'(max_b), int'(e.c1 == 9));
        check({tag, ".min_a"}, int'(min_a), int'(e.c0 == 0));
        check({tag, ".min_b"}, int'(min_b), int'(e.c1 == 0));
`ifdef UDC_EVENT_FLAG_EN
        check({tag, ".flag_a"}, int'(flag_a), int'(e.f0));
        check({tag, ".flag_b"}, int'(flag_b), int'(e.f1));
`endif
    endtask

    // Monitor: counter presents a new result every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_outputs("edge", e);
        end
    end

    initial begin
        exp_t z;
        z.c0 = 0; z.c1 = 0; z.w0 = 0; z.w1 = 0; z.f0 = 0; z.f1 = 0;
        rst_n = 1'b0; enable = 1'b0; direction = 1'b1; load = 1'b0;
        load_value = 8'd0; saturate = 1'b0;
`ifdef UDC_EVENT_FLAG_EN
        event_clr = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #2 check_outputs("reset", z);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running up count through the 8-bit wrap.
        repeat (300) step(1, 1, 0, 0, 0, 0);

        // Decimal modulus, wrap mode.
        step(0, 1, 1, 0, 0, 0);
        repeat (12) step(1, 1, 0, 0, 0, 0);
        repeat (12) step(1, 0, 0, 0, 0, 0);

        // Saturate mode clamps at both ends.
        step(0, 1, 1, 0, 1, 0);
        repeat (15) step(1, 1, 0, 0, 1, 0);
        repeat (15) step(1, 0, 0, 0, 1, 0);

        // Load priority and clamping.
        step(1, 0, 1, 5, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 200, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Event flag: saturated set, lone clear, clear coincident with a wrap.
        step(0, 1, 1, 9, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 1, 9, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Async reset mid-count at 7, pulsed between edges.
        step(0, 1, 1, 6, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1.5 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("async_rst", z);
        #2 rst_n = 1'b1;
        step(1, 1, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(3, 0) != 0, 1'($urandom), $urandom_range(15, 0) == 0,
                 int'($urandom_range(255, 0)), 1'($urandom), $urandom_range(7, 0) == 0);
        end

        @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d expected=0 pending entries", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
